// File: rtl/song_sequencer.sv
// Song sequencer: walks a song's note ROM, holding each note for its beat
// duration, and reports completion to the menu controller.
module song_sequencer #(
    parameter int unsigned BASE_SHIFT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] song,
    input  logic       abort,
    input  logic       beat_tick,
    input  logic       pause,
    output logic [9:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [4:0] note,
    output logic       note_valid,
    output logic [8:0] note_count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  song_q;
    logic [7:0]  offset_q;
    logic [2:0]  beats_q;
    logic [9:0]  rom_addr_q;
    logic [4:0]  note_q;
    logic        note_valid_q;
    logic [8:0]  note_count_q;
    logic        busy_q;
    logic        done_q;

    logic [9:0]  addr_d;
    logic [8:0]  count_inc_d;

    assign addr_d      = ({8'b0, song_q} << BASE_SHIFT) + {2'b0, offset_q};
    assign count_inc_d = (note_count_q == '1) ? note_count_q : note_count_q + 9'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            song_q       <= '0;
            offset_q     <= '0;
            beats_q      <= '0;
            rom_addr_q   <= '0;
            note_q       <= '0;
            note_valid_q <= 1'b0;
            note_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Abort outranks start, beat ticks and the end marker.
                state_q      <= S_IDLE;
                note_valid_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            song_q       <= song;
                            offset_q     <= '0;
                            note_count_q <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= (song == 2'd3) ? S_DONE : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        rom_addr_q <= addr_d;
                        state_q    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (rom_data == 8'h00) begin
                            state_q <= S_DONE;
                        end else begin
                            note_q       <= rom_data[7:3];
                            beats_q      <= (rom_data[2:0] == 3'd0) ? 3'd1 : rom_data[2:0];
                            note_valid_q <= 1'b1;
                            state_q      <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        // Paused ticks are dropped, not remembered.
                        if (beat_tick && !pause) begin
                            if (beats_q == 3'd1) begin
                                note_valid_q <= 1'b0;
                                note_count_q <= count_inc_d;
                                if (offset_q == 8'hFF) begin
                                    state_q <= S_DONE;
                                end else begin
                                    offset_q <= offset_q + 8'd1;
                                    state_q  <= S_FETCH;
                                end
                            end else begin
                                beats_q <= beats_q - 3'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign note_count = note_count_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter BASE_SHIFT, default 8, meaning song base address = song << BASE_SHIFT (256 ROM words per song).
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin the song selected by the menu (menu resetComp pulse).
REQ-005 SHALL have port song, input, 2, song index; sampled only on an accepted start.
REQ-006 SHALL have port abort, input, 1, level; forces return to IDLE.
REQ-007 SHALL have port beat_tick, input, 1, one-cycle beat strobe from the tempo divider.
REQ-008 SHALL have port pause, input, 1, level; freezes beat counting.
REQ-009 SHALL have port rom_addr, output, 10, registered note-ROM address.
REQ-010 SHALL have port rom_data, input, 8, ROM word; [7:3] note code, [2:0] duration in beats; valid exactly 1 cycle after rom_addr changes.
REQ-011 SHALL have port note, output, 5, current note code to display and scorer.
REQ-012 SHALL have port note_valid, output, 1, high while a note is being played.
REQ-013 SHALL have port note_count, output, 9, notes completed this song.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle end-of-song pulse to the menu controller.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT, PLAY, DONE.
REQ-017 IDLE: start=1 and abort=0 SHALL latch song, clear offset and note_count, and enter FETCH; start in any other state SHALL be ignored.
REQ-018 start with song=3 SHALL go directly to DONE (no ROM access).
REQ-019 FETCH: rom_addr SHALL be {song,8'b0}+offset, registered; next state WAIT unconditionally.
REQ-020 WAIT: rom_data==8'h00 (end marker) SHALL go to DONE; otherwise note<=rom_data[7:3], beat counter<=rom_data[2:0] (0 loads 1), note_valid<=1, enter PLAY.
REQ-021 Latency from accepted start to note_valid=1 SHALL be exactly 3 clock cycles.
REQ-022 PLAY: beat_tick=1 and pause=0 SHALL decrement the beat counter; beat_tick while pause=1 SHALL be discarded, not deferred.
REQ-023 PLAY: a counted beat_tick with counter==1 SHALL clear note_valid, increment note_count, and go to FETCH with offset+1, or to DONE if offset==255 (no wrap into next song).
REQ-024 note SHALL hold its value after note_valid falls until the next WAIT load.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; busy SHALL be 0 in the IDLE cycle after DONE.
REQ-026 abort=1 in any state SHALL enter IDLE next cycle, clearing note_valid, with no done pulse; abort SHALL take priority over start, beat_tick and end marker.
REQ-027 note_count SHALL saturate at 511 and remain readable in IDLE until the next accepted start.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state IDLE, rom_addr=0, note=0, note_valid=0, note_count=0, busy=0, done=0, offset=0, latched song=0.
REQ-029 Deassertion of reset_n mid-song SHALL resume from IDLE only; no partial song continues.

Verification
REQ-030 Reset, start with song=1, ROM[256]=8'h0A, ROM[257]=8'h00 -> rom_addr=256, note_valid=1 on cycle 3 with note=1; after 2 beat_ticks note_valid=0, rom_addr=257, done pulse, note_count=1.
REQ-031 Duration 0 word 8'h18 -> note=3 held for exactly 1 beat_tick.
REQ-032 pause=1 during PLAY with 3 beat_ticks, then pause=0 -> note_valid stays 1; counter unchanged; completes after full duration of unpaused ticks.
REQ-033 ROM song 0 with no end marker -> 256 notes played, done after offset 255, rom_addr never exceeds 255.
REQ-034 abort asserted together with beat_tick in PLAY -> IDLE next cycle, note_valid=0, done never pulses; start with song=3 -> done on cycle 2, no FETCH.
REQ-035 reset_n pulled low mid-PLAY (asynchronous to clk) -> all outputs 0 immediately; start while busy has no effect.
